// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter family: FSM encodings,
// default sizing and the timeout counter width helper.
package mem_arbiter_pkg;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  localparam int DEF_N_CORES = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int WORD_W      = 32;

  // Counter must hold TIMEOUT and is never narrower than 8 bits.
  function automatic int cnt_width(input int timeout);
    cnt_width = ($clog2(timeout + 1) < 8) ? 8 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from last_i+1, wrapping modulo N.
module rr_priority_picker
  import mem_arbiter_pkg::*;
#(
  parameter int N = DEF_N_CORES
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [$clog2(N)-1:0] grant_o,
  output logic                 valid_o
);

  localparam int GW = $clog2(N);

  logic [GW-1:0] cand_s;

  // Scan farthest-first so the nearest requester after last_i overwrites.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    cand_s  = '0;
    for (int k = N; k >= 1; k--) begin
      cand_s  = GW'((int'(last_i) + k) % N);
      grant_o = req_i[cand_s] ? cand_s : grant_o;
      valid_o = valid_o | req_i[cand_s];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-outstanding data-memory port among
// N_CORES cores; stalls losers via core_mem_wait and flags memory timeouts.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CORES-1:0]         core_mem_read,
  input  logic [N_CORES-1:0]         core_mem_write,
  input  logic [N_CORES*32-1:0]      core_mem_addr,
  input  logic [N_CORES*32-1:0]      core_mem_data_w,
  output logic [N_CORES*32-1:0]      core_mem_data_r,
  output logic [N_CORES-1:0]         core_mem_wait,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_ready,
  output logic [$clog2(N_CORES)-1:0] grant,
  output logic                       err
);

  localparam int GW    = $clog2(N_CORES);
  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [N_CORES-1:0] req_s;
  logic [GW-1:0]      pick_s;
  logic               pick_valid_s;
  logic               busy_s;

  assign req_s  = core_mem_read | core_mem_write;
  assign busy_s = (state_q == ARB_BUSY);

  rr_priority_picker #(.N(N_CORES)) u_picker (
    .req_i   (req_s),
    .last_i  (last_q),
    .grant_o (pick_s),
    .valid_o (pick_valid_s)
  );

  // Next-state logic: grant in IDLE, hold the committed access in BUSY.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_d   = ARB_BUSY;
          grant_d   = pick_s;
          mem_req_d = 1'b1;
          mem_we_d  = core_mem_write[pick_s];
          addr_d    = core_mem_addr[int'(pick_s)*WORD_W +: WORD_W];
          wdata_d   = core_mem_data_w[int'(pick_s)*WORD_W +: WORD_W];
        end else begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (mem_ready) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          last_d    = grant_q;
          cnt_d     = '0;
        end else begin
          // Saturate so a stuck memory cannot wrap the counter.
          if (cnt_q < CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; core 0 gets first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= GW'(N_CORES - 1);
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // A requesting core stalls until the cycle its own access completes.
  always_comb begin
    core_mem_wait = '0;
    for (int i = 0; i < N_CORES; i++) begin
      core_mem_wait[i] = req_s[i] & ~(busy_s & (grant_q == GW'(i)) & mem_ready);
    end
  end

  assign core_mem_data_r = {N_CORES{mem_rdata}};
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign grant           = grant_q;
  assign err             = err_q;

endmodule
